uart_rx_par: RTL
================

# uart_rx_par

Receive half of the parity-capable UART. Oversamples the serial line with the shared 16x baud tick, recovers start, data (LSB first), even-parity and stop bits, and delivers one byte per frame with parity and framing status. Sits between the pad-side `rx` line and the receive FIFO / host logic. Frame format is identical to the team's `uart_tx` output, so the two blocks form a loopback pair.

## Interface
- `DBIT`, 8, data bits per frame; legal range 5–8.
- `SB_TICK`, 16, s_ticks per stop bit: 16, 24 or 32 for 1, 1.5 or 2 stop bits.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  one-clk pulse at 16x the baud rate, from the shared baud generator.
- `rx`  in  1  serial input; idles high; asynchronous to `clk`.
- `dout`  out  8  received data, right-aligned in bits [DBIT-1:0]; unused upper bits are 0.
- `rx_done_tick`  out  1  one-clk pulse; frame complete.
- `parity_err`  out  1  parity check failed on the last frame.
- `frame_err`  out  1  stop bit sampled low on the last frame.

## Operation
- `rx` passes through a 2-flop synchronizer before any other use; the synchronizer flops reset to 1. `rx_s` is the synchronized line and `rx_d` is `rx_s` delayed by one clk.
- States: IDLE, START, DATA, PARITY, STOP. Counters: `s` (4 bit, tick count within a bit) and `n` (3 bit, data-bit index). Shift register `b` (8 bit). Parity accumulator `p` (1 bit).
- IDLE: on a falling edge (`rx_d`=1, `rx_s`=0), go to START with `s`=0 and `p`=0. A low level alone never starts a frame.
- START: on each `s_tick`, when `s`==7 (mid-bit), check the line. If `rx_s`=0, go to DATA with `s`=0 and `n`=0. If `rx_s`=1, the start was false: return to IDLE with no outputs. Otherwise `s`++.
- DATA: on each `s_tick`, when `s`==15, sample `rx_s`, shift it in at bit DBIT-1 of `b` (right-shift), set `p` ^= `rx_s` and `s`=0. When `n`==DBIT-1, go to PARITY; otherwise `n`++.
- PARITY: when `s`==15 on `s_tick`, compute `perr` = `p` ^ `rx_s` (even parity), set `s`=0 and go to STOP.
- STOP: when `s`==SB_TICK-1 on `s_tick`, compute `ferr` = !`rx_s` and go to IDLE. On the next edge, `rx_done_tick`=1 and `dout`, `parity_err` and `frame_err` load.
- Bits of `b` above DBIT-1 read as 0 at load.
- Any illegal state encoding returns to IDLE with all counters cleared.
- Break condition (line held low): the frame completes with `frame_err`=1. No new frame starts until `rx` returns high and falls again.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `parity_err`=0, `frame_err`=0, state IDLE, `s`=`n`=`p`=0, `b`=0.
- Asserting `reset_n` low mid-frame aborts the frame immediately. No done pulse is issued for the aborted frame.
- Start-detect latency: 2 clk through the synchronizer plus 1 clk for the edge compare.
- Sample points:
  - start bit: 8th `s_tick` after detection.
  - each later bit: 16 ticks after the previous sample.
  - stop bit: SB_TICK ticks after the parity sample.
- `rx_done_tick` rises exactly one clk after the qualifying STOP `s_tick` and lasts exactly 1 clk.
- `dout`, `parity_err` and `frame_err` change only on the edge that asserts `rx_done_tick`, and hold until the next frame completes. There is no consumer handshake: overrun is the consumer's responsibility.
- `s_tick` is ignored in IDLE. Counters advance only on `s_tick` cycles.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state and the `p` accumulator exist, and the frame is start + DBIT + parity + stop.
- `UART_RX_PARITY_EN` not defined: DATA goes directly to STOP, the frame is start + DBIT + stop, and `parity_err` is tied to 0.
- The setting must match the peer transmitter's configuration.

## Test plan
All scenarios use `s_tick` every 4 clk (64 clk per bit), DBIT=8 and SB_TICK=16, with parity enabled unless stated.
- Frame 0xA5 with parity bit 0 -> `rx_done_tick` pulses once, `dout`=0xA5, `parity_err`=0, `frame_err`=0.
- Frame 0x01 with parity bit 0 (wrong; 0x01 needs parity bit 1) -> `dout`=0x01, `parity_err`=1.
- Frame 0x3C with stop bit driven 0 -> `frame_err`=1. Then hold `rx` low for 2 frames: no second done pulse until `rx` goes high and falls again.
- 4-tick low glitch on idle `rx` -> false start detected, returns to IDLE, no `rx_done_tick`, outputs unchanged.
- `reset_n` pulsed low during data bit 3 of frame 0xFF -> all outputs 0 and no done pulse. A subsequent clean 0x5A frame is received correctly.
- Parity disabled build, back-to-back frames 0x00 then 0xFF -> two done pulses 640 clk apart, `dout` 0x00 then 0xFF, `parity_err` stays 0.

Source files
------------

// File: rtl/uart_rx_par.sv
// 16x-oversampled UART receiver: start, DBIT data (LSB first), even parity, stop.
// Define UART_RX_PARITY_EN to include the parity bit; otherwise parity_err is 0.
module uart_rx_par #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);
  localparam logic [7:0]    MASK   = 8'((1 << DBIT) - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [2:0]      n;
  logic [7:0]      b;
  logic            rx_q;
  logic            rx_s;
  logic            rx_d;
  logic            ferr_q;
  logic            done_pend;
`ifdef UART_RX_PARITY_EN
  logic            p;
  logic            perr_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_q <= rx;
      rx_s <= rx_q;
      rx_d <= rx_s;
    end
  end

  // Status is captured at the stop sample and published one edge later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      ferr_q       <= 1'b0;
      done_pend    <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p            <= 1'b0;
      perr_q       <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= done_pend;
      done_pend    <= 1'b0;
      if (done_pend) begin
        dout      <= b & MASK;
        frame_err <= ferr_q;
`ifdef UART_RX_PARITY_EN
        parity_err <= perr_q;
`endif
      end
      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            state <= START;
            s     <= '0;
`ifdef UART_RX_PARITY_EN
            p     <= 1'b0;
`endif
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              s <= '0;
              b <= (b >> 1) | (8'(rx_s) << (DBIT - 1));
`ifdef UART_RX_PARITY_EN
              p <= p ^ rx_s;
`endif
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 3'd1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == S_LAST) begin
              perr_q <= p ^ rx_s;
              s      <= '0;
              state  <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              ferr_q    <= !rx_s;
              done_pend <= 1'b1;
              state     <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          s     <= '0;
          n     <= '0;
          b     <= '0;
`ifdef UART_RX_PARITY_EN
          p     <= 1'b0;
`endif
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
